// File: rtl/demux_1_4_32_reg.sv
// Registered 1-to-4 stream demultiplexer.
// Each channel has a one-entry holding register with a valid/ready handshake.
`timescale 1ns/1ps
module demux_1_4_32_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_0,
    output logic [WIDTH-1:0] data_1,
    output logic [WIDTH-1:0] data_2,
    output logic [WIDTH-1:0] data_3,
    output logic             valid_0,
    output logic             valid_1,
    output logic             valid_2,
    output logic             valid_3,
    input  logic             ready_0,
    input  logic             ready_1,
    input  logic             ready_2,
    input  logic             ready_3,
    output logic [CNT_W-1:0] count_0,
    output logic [CNT_W-1:0] count_1,
    output logic [CNT_W-1:0] count_2,
    output logic [CNT_W-1:0] count_3
);

    logic [3:0][WIDTH-1:0] data_q;
    logic [3:0][CNT_W-1:0] count_q;
    logic [3:0]            valid_q;
    logic [3:0]            ready;
    logic [3:0]            free;
    logic [3:0]            wr;
    logic [3:0]            drain;
    logic                  accept;

    assign ready = {ready_3, ready_2, ready_1, ready_0};

    // A full channel whose consumer is taking its word can be refilled
    // on the same edge, so it counts as free.
    assign drain = valid_q & ready;
    assign free  = ~valid_q | ready;

    assign in_ready = enable & rst_n & free[select];
    assign accept   = in_valid & in_ready;

    always_comb begin
        wr = 4'b0000;
        if (accept) begin
            wr[select] = 1'b1;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q[n]  <= '0;
                valid_q[n] <= 1'b0;
                count_q[n] <= '0;
            end else begin
                if (wr[n]) begin
                    data_q[n]  <= data_in;
                    valid_q[n] <= 1'b1;
                end else if (drain[n]) begin
                    valid_q[n] <= 1'b0;
                end
                if (drain[n]) begin
                    count_q[n] <= count_q[n] + CNT_W'(1);
                end
            end
        end
    end

    assign data_0  = data_q[0];
    assign data_1  = data_q[1];
    assign data_2  = data_q[2];
    assign data_3  = data_q[3];
    assign valid_0 = valid_q[0];
    assign valid_1 = valid_q[1];
    assign valid_2 = valid_q[2];
    assign valid_3 = valid_q[3];
    assign count_0 = count_q[0];
    assign count_1 = count_q[1];
    assign count_2 = count_q[2];
    assign count_3 = count_q[3];

endmodule
